// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer and a per-bit timing counter.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
  parameter int CLKS_PER_BIT = 12,
  parameter int DATA_BITS    = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 frame_error,
  output logic                 parity_error
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK} state_t;

  state_t               state;
  logic                 rx_m, rx_s;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shift;
`ifdef UART_RX_PARITY_EN
  logic                 par;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par          <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
      case (state)
        S_IDLE: if (!rx_s) begin
          state <= S_START;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        // Re-check the line at mid start bit to reject glitches.
        S_START: if (cnt == CNT_MID) begin
          cnt <= '0;
          if (!rx_s) begin
            state <= S_DATA;
            idx   <= '0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end else cnt <= cnt + 1'b1;
        S_DATA: if (cnt == CNT_LAST) begin
          cnt   <= '0;
          shift <= {rx_s, shift[DATA_BITS-1:1]};
          idx   <= idx + 1'b1;
          if (idx == IDX_LAST)
`ifdef UART_RX_PARITY_EN
            state <= S_PARITY;
`else
            state <= S_STOP;
`endif
        end else cnt <= cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (cnt == CNT_LAST) begin
          cnt   <= '0;
          par   <= rx_s;
          state <= S_STOP;
        end else cnt <= cnt + 1'b1;
`endif
        // A low stop bit wins over parity and parks in S_BRK until the line recovers.
        S_STOP: if (cnt == CNT_LAST) begin
          cnt <= '0;
          if (rx_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (^{shift, par}) parity_error <= 1'b1;
            else begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end
`else
            rx_data  <= shift;
            rx_valid <= 1'b1;
`endif
          end else begin
            frame_error <= 1'b1;
            state       <= S_BRK;
          end
        end else cnt <= cnt + 1'b1;
        S_BRK: if (rx_s) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: scoreboard of expected bytes checked on each rx_valid.
module tb_uart_rx;
  localparam int CPB = 12;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT = 2 + CPB/2 + 9*CPB + PB*CPB;
  localparam int FRAME = (10 + PB) * CPB;

  logic       CLK = 1'b0, RST = 1'b1, rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, busy, frame_error, parity_error;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .CLK(CLK), .RST(RST), .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .frame_error(frame_error), .parity_error(parity_error)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  int valid_cnt = 0, fe_cnt = 0, pe_cnt = 0;
  int t_fall = 0, t_valid = 0, t_valid_prev = 0;
  logic [7:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (rx_valid | frame_error | parity_error)
      chk("strobe_onehot", 32'($onehot0({rx_valid, frame_error, parity_error})), 32'd1);
    if (rx_valid) begin
      valid_cnt++;
      t_valid_prev = t_valid;
      t_valid = cyc;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("sb_data", 32'(rx_data), 32'(sb.pop_front()));
    end
    if (frame_error)  fe_cnt++;
    if (parity_error) pe_cnt++;
  end

  task automatic send_raw(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 0) t_fall = cyc;
      rx_in = bits[i];
      repeat (CPB) @(negedge CLK);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    if (stop_b) sb.push_back(b);
`ifdef UART_RX_PARITY_EN
    send_raw({stop_b, ^b, b, 1'b0}, 11);
`else
    send_raw({1'b1, stop_b, b, 1'b0}, 10);
`endif
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_p(input logic [7:0] b, input logic par_b, input logic stop_b);
    if (stop_b && !(^{b, par_b})) sb.push_back(b);
    send_raw({stop_b, par_b, b, 1'b0}, 11);
  endtask
`endif

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_data"},  32'(rx_data), 32'd0);
    chk({tag, "_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_fe"},    32'(frame_error), 32'd0);
    chk({tag, "_pe"},    32'(parity_error), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pb;
    int d;
    repeat (3) @(negedge CLK);
    chk_reset_outs("rst");
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    // single frame, latency and idle afterwards
    send_frame(8'hA5, 1'b1);
    repeat (10) @(negedge CLK);
    chk("t1_cnt", 32'(valid_cnt), 32'd1);
    d = t_valid - t_fall;
    chk("t1_latency", 32'(d >= LAT-1 && d <= LAT+1), 32'd1);
    chk("t1_data", 32'(rx_data), 32'hA5);
    chk("t1_busy", 32'(busy), 32'd0);

    // zero-gap back-to-back frames
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (10) @(negedge CLK);
    chk("t2_cnt", 32'(valid_cnt), 32'd3);
    d = t_valid - t_valid_prev;
    chk("t2_gap", 32'(d >= FRAME-1 && d <= FRAME+1), 32'd1);
    chk("t2_data", 32'(rx_data), 32'hFF);

    // start-bit glitch
    rx_in = 1'b0;
    repeat (3) @(negedge CLK);
    rx_in = 1'b1;
    @(negedge CLK);
    chk("t3_busy_rise", 32'(busy), 32'd1);
    repeat (20) @(negedge CLK);
    chk("t3_busy_fall", 32'(busy), 32'd0);
    chk("t3_valid_cnt", 32'(valid_cnt), 32'd3);
    chk("t3_fe_cnt", 32'(fe_cnt), 32'd0);

    // bad stop bit followed by a held-low line
    send_frame(8'h3C, 1'b0);
    repeat (50) @(negedge CLK);
    chk("t4_fe_cnt", 32'(fe_cnt), 32'd1);
    chk("t4_data_kept", 32'(rx_data), 32'hFF);
    chk("t4_busy_brk", 32'(busy), 32'd1);
    chk("t4_valid_cnt", 32'(valid_cnt), 32'd3);
    rx_in = 1'b1;
    repeat (5) @(negedge CLK);
    chk("t4_busy_idle", 32'(busy), 32'd0);
    chk("t4_fe_once", 32'(fe_cnt), 32'd1);

    // reset in the middle of data bit 3
    pb = 8'h5A;
    rx_in = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      rx_in = pb[i];
      repeat (CPB) @(negedge CLK);
    end
    rx_in = pb[3];
    repeat (CPB/2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk_reset_outs("t5_rst");
    RST = 1'b0;
    rx_in = 1'b1;
    repeat (30) @(negedge CLK);
    chk("t5_no_valid", 32'(valid_cnt), 32'd3);
    chk("t5_idle", 32'(busy), 32'd0);
    send_frame(8'h81, 1'b1);
    repeat (10) @(negedge CLK);
    chk("t5_cnt", 32'(valid_cnt), 32'd4);
    chk("t5_data", 32'(rx_data), 32'h81);

`ifdef UART_RX_PARITY_EN
    send_frame_p(8'h07, 1'b1, 1'b1);
    repeat (10) @(negedge CLK);
    chk("t6_good_cnt", 32'(valid_cnt), 32'd5);
    chk("t6_good_data", 32'(rx_data), 32'h07);
    send_frame_p(8'h07, 1'b0, 1'b1);
    repeat (10) @(negedge CLK);
    chk("t6_pe_cnt", 32'(pe_cnt), 32'd1);
    chk("t6_no_valid", 32'(valid_cnt), 32'd5);
    chk("t6_data_kept", 32'(rx_data), 32'h07);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("pe_total", 32'(pe_cnt), 32'(PB));
    chk("fe_total", 32'(fe_cnt), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
